// File: rtl/cdc_bus_arbiter.sv
// cdc_bus_arbiter: source-domain front end that shares a single bus
// synchronizer channel among NUM_REQ requesters. A granted word is driven
// onto unsync_bus and qualified by bus_enable for HOLD_CYCLES cycles. A
// GAP_CYCLES guard gap follows, so the far side always sees a clean rising
// edge on bus_enable.
// Optional build macro: CDC_ARB_RR_EN selects round-robin arbitration.
// When it is undefined, the arbiter uses fixed priority (index 0 highest).
module cdc_bus_arbiter #(
    parameter int BUS_WIDTH   = 8,
    parameter int NUM_REQ     = 4,
    parameter int ID_WIDTH    = 2,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*BUS_WIDTH-1:0] data_in,
    output logic [NUM_REQ-1:0]           ack,
    output logic [BUS_WIDTH-1:0]         unsync_bus,
    output logic                         bus_enable,
    output logic [ID_WIDTH-1:0]          grant_id,
    output logic                         busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES - 1);

    logic [1:0]                        state;
    logic [7:0]                        cnt;
    logic [NUM_REQ-1:0][BUS_WIDTH-1:0] words;
    logic [ID_WIDTH-1:0]               win;
    logic [NUM_REQ-1:0]                win_oh;

    // Packed lane view of the flat requester word bus.
    assign words = data_in;
    assign busy  = (state != S_IDLE);

`ifdef CDC_ARB_RR_EN
    localparam logic [ID_WIDTH:0] NR_W = (ID_WIDTH+1)'(NUM_REQ);

    logic [ID_WIDTH-1:0] rr_ptr;
    logic [ID_WIDTH:0]   dist;
    logic [ID_WIDTH:0]   best;

    // Pick the requester closest after rr_ptr (rotated distance, ties impossible).
    always_comb begin
        win  = '0;
        best = '1;
        dist = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            dist = (ID_WIDTH+1)'(j + NUM_REQ - 1) - {1'b0, rr_ptr};
            if (dist >= NR_W) dist = dist - NR_W;
            if (req[j] && (dist < best)) begin
                best = dist;
                win  = j[ID_WIDTH-1:0];
            end
        end
    end

    // Remember the last winner so the next search starts just past it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rr_ptr <= ID_WIDTH'(NUM_REQ - 1);
        else if (state == S_IDLE && |req)
            rr_ptr <= win;
    end
`else
    // Fixed priority: the lowest pending index wins.
    always_comb begin
        win = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--)
            if (req[j]) win = j[ID_WIDTH-1:0];
    end
`endif

    // One-hot form of the winner for the ack pulse.
    always_comb begin
        win_oh = '0;
        for (int j = 0; j < NUM_REQ; j++)
            win_oh[j] = (win == j[ID_WIDTH-1:0]);
    end

    // Grant / hold / guard-gap sequencer; every output is registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            ack        <= '0;
            unsync_bus <= '0;
            bus_enable <= 1'b0;
            grant_id   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        unsync_bus <= words[win];
                        grant_id   <= win;
                        ack        <= win_oh;
                        bus_enable <= 1'b1;
                        cnt        <= HOLD_LOAD;
                        state      <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    ack <= '0;
                    if (cnt == 8'd0) begin
                        bus_enable <= 1'b0;
                        cnt        <= GAP_LOAD;
                        state      <= S_GAP;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_GAP: begin
                    if (cnt == 8'd0) state <= S_IDLE;
                    else             cnt   <= cnt - 8'd1;
                end
                default: begin
                    state      <= S_IDLE;
                    ack        <= '0;
                    bus_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cdc_bus_arbiter.sv
// Self-checking bench for cdc_bus_arbiter: scoreboard of expected grants,
// per-scenario tasks, and a pulse-shape monitor on bus_enable.
module tb_cdc_bus_arbiter;

    localparam int BW = 8;
    localparam int NR = 4;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [NR-1:0]    req;
    logic [NR*BW-1:0] data_in;
    logic [NR-1:0]    ack;
    logic [BW-1:0]    unsync_bus;
    logic             bus_enable;
    logic [IW-1:0]    grant_id;
    logic             busy;

    logic [NR-1:0]    req1;
    logic [NR*BW-1:0] data1;
    logic [NR-1:0]    ack1;
    logic [BW-1:0]    bus1;
    logic             be1;
    logic [IW-1:0]    gid1;
    logic             busy1;

    cdc_bus_arbiter #(.BUS_WIDTH(BW), .NUM_REQ(NR), .ID_WIDTH(IW),
                      .HOLD_CYCLES(4), .GAP_CYCLES(4)) u_dut (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in), .ack(ack),
        .unsync_bus(unsync_bus), .bus_enable(bus_enable),
        .grant_id(grant_id), .busy(busy));

    cdc_bus_arbiter #(.BUS_WIDTH(BW), .NUM_REQ(NR), .ID_WIDTH(IW),
                      .HOLD_CYCLES(1), .GAP_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .req(req1), .data_in(data1), .ack(ack1),
        .unsync_bus(bus1), .bus_enable(be1),
        .grant_id(gid1), .busy(busy1));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [BW-1:0] word;
    } exp_t;
    exp_t sb[$];

    // Pulse-shape monitor: 4-cycle enable, gap >= 5, bus stable while enabled.
    bit         mon_en = 1'b0;
    bit         m_prev, m_seen;
    int         m_hi, m_lo;
    logic [BW-1:0] m_bus;
    always @(negedge clk) begin
        if (!mon_en || !rst) begin
            m_prev = 1'b0; m_seen = 1'b0; m_hi = 0; m_lo = 0;
        end else begin
            if (bus_enable) begin
                if (!m_prev) begin
                    if (m_seen) begin
                        total++;
                        if (m_lo < 5) begin
                            bad++;
                            $display("FAIL gap_len: got %0d want >=5", m_lo);
                        end
                    end
                    m_hi = 0;
                end else begin
                    total++;
                    if (unsync_bus !== m_bus) begin
                        bad++;
                        $display("FAIL bus_stable: got %h want %h", unsync_bus, m_bus);
                    end
                end
                m_hi++;
            end else begin
                if (m_prev) begin
                    total++;
                    if (m_hi != 4) begin
                        bad++;
                        $display("FAIL pulse_len: got %0d want 4", m_hi);
                    end
                    m_seen = 1'b1;
                    m_lo   = 0;
                end
                m_lo++;
            end
            m_prev = bus_enable;
            m_bus  = unsync_bus;
        end
    end

    task automatic set_word(input int p, input logic [BW-1:0] w);
        data_in[p*BW +: BW] = w;
    endtask

    // Waits (bounded) for an ack pulse on the main DUT; no checking here.
    task automatic wait_ack(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ack != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
    endtask

    task automatic test_reset();
        bit ok;
        mon_en = 1'b0;
        rst = 1'b0; req = '0; req1 = '0; data_in = '0; data1 = '0;
        repeat (2) @(negedge clk);
        total++;
        if ({ack, unsync_bus, bus_enable, grant_id, busy} !== '0) begin
            bad++;
            $display("FAIL reset_init: got %h want 0",
                     {ack, unsync_bus, bus_enable, grant_id, busy});
        end
        rst = 1'b1;
        set_word(0, 8'h5A);
        req = 4'b0001;
        wait_ack(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL reset_grant_timeout: got no ack want ack");
        end
        @(negedge clk);
        total++;
        if (bus_enable !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_prehold: got be=%b busy=%b want 1 1", bus_enable, busy);
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if ({ack, unsync_bus, bus_enable, grant_id, busy} !== '0) begin
            bad++;
            $display("FAIL reset_mid: got %h want 0",
                     {ack, unsync_bus, bus_enable, grant_id, busy});
        end
        req = '0;
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        total++;
        if ({ack, unsync_bus, bus_enable, grant_id, busy} !== '0) begin
            bad++;
            $display("FAIL reset_release: got %h want 0",
                     {ack, unsync_bus, bus_enable, grant_id, busy});
        end
    endtask

    task automatic test_single();
        bit   ok;
        exp_t e;
        int   n_be, n_busy;
        mon_en = 1'b1;
        set_word(0, 8'h11); set_word(1, 8'h22); set_word(2, 8'hA5); set_word(3, 8'h44);
        req = 4'b0100;
        sb.push_back('{id: 2'd2, word: 8'hA5});
        wait_ack(ok);
        e = sb.pop_front();
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL single_timeout: got no ack want ack");
        end else begin
            total++;
            if (ack !== (4'b0001 << e.id)) begin
                bad++; $display("FAIL single_ack: got %b want %b", ack, 4'b0001 << e.id);
            end
            total++;
            if (unsync_bus !== e.word) begin
                bad++; $display("FAIL single_bus: got %h want %h", unsync_bus, e.word);
            end
            total++;
            if (grant_id !== e.id) begin
                bad++; $display("FAIL single_gid: got %0d want %0d", grant_id, e.id);
            end
            req = '0;
            n_be = 1; n_busy = 1;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (i == 0) begin
                    total++;
                    if (ack !== '0) begin
                        bad++; $display("FAIL single_ack_drop: got %b want 0", ack);
                    end
                end
                if (bus_enable) n_be++;
                if (busy) n_busy++;
                else break;
            end
            total++;
            if (n_be != 4) begin
                bad++; $display("FAIL single_be_len: got %0d want 4", n_be);
            end
            total++;
            if (n_busy != 8) begin
                bad++; $display("FAIL single_busy_len: got %0d want 8", n_busy);
            end
        end
        req = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_ignored();
        bit   ok;
        exp_t e;
        set_word(1, 8'h3C);
        req = 4'b0010;
        sb.push_back('{id: 2'd1, word: 8'h3C});
        wait_ack(ok);
        e = sb.pop_front();
        req = '0;
        total++;
        if (!ok || unsync_bus !== e.word || grant_id !== e.id) begin
            bad++;
            $display("FAIL ign_grant: got ok=%b bus=%h id=%0d want 1 %h %0d",
                     ok, unsync_bus, grant_id, e.word, e.id);
        end
        @(negedge clk);
        set_word(1, 8'hFF);
        wait_idle();
        repeat (2) @(negedge clk);
        total++;
        if (unsync_bus !== 8'h3C) begin
            bad++; $display("FAIL ign_hold: got %h want 3c", unsync_bus);
        end
        req = 4'b0010;
        sb.push_back('{id: 2'd1, word: 8'hFF});
        wait_ack(ok);
        e = sb.pop_front();
        req = '0;
        total++;
        if (!ok || unsync_bus !== e.word) begin
            bad++; $display("FAIL ign_next: got ok=%b bus=%h want 1 %h", ok, unsync_bus, e.word);
        end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        bit   ok;
        exp_t e;
        logic [BW-1:0] w [NR];
        int   ids [5];
        w[0] = 8'h10; w[1] = 8'h21; w[2] = 8'h32; w[3] = 8'h43;
        for (int p = 0; p < NR; p++) set_word(p, w[p]);
        // Fresh reset so the round-robin pointer restarts from NUM_REQ-1.
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
`ifdef CDC_ARB_RR_EN
        ids = '{0, 1, 2, 3, 0};
        req = 4'b1111;
`else
        ids = '{0, 0, 0, 1, 3};
        req = 4'b1011;
`endif
        for (int k = 0; k < 5; k++)
            sb.push_back('{id: IW'(ids[k]), word: w[ids[k]]});
        for (int k = 0; k < 5; k++) begin
            wait_ack(ok);
            e = sb.pop_front();
            total++;
            if (!ok) begin
                bad++; $display("FAIL b2b_timeout[%0d]: got no ack want ack", k);
                break;
            end
            total++;
            if (ack !== (4'b0001 << e.id) || grant_id !== e.id) begin
                bad++; $display("FAIL b2b_grant[%0d]: got ack=%b id=%0d want id=%0d",
                                k, ack, grant_id, e.id);
            end
            total++;
            if (unsync_bus !== e.word) begin
                bad++; $display("FAIL b2b_bus[%0d]: got %h want %h", k, unsync_bus, e.word);
            end
`ifdef CDC_ARB_RR_EN
            if (k == 4) req = '0;
`else
            if (k == 2) req[0] = 1'b0;
            if (k == 3) req[1] = 1'b0;
            if (k == 4) req[3] = 1'b0;
`endif
        end
        req = '0;
        sb.delete();
        wait_idle();
        mon_en = 1'b0;
    endtask

    task automatic test_param_edge();
        bit ok;
        bit exp_v;
        data1 = '0;
        data1[BW-1:0] = 8'h77;
        req1 = 4'b0001;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ack1[0]) begin ok = 1'b1; break; end
        end
        total++;
        if (!ok) begin
            bad++; $display("FAIL edge_timeout: got no ack want ack");
        end else begin
            for (int i = 0; i < 9; i++) begin
                if (i > 0) @(negedge clk);
                exp_v = (i % 3 == 0);
                total++;
                if (be1 !== exp_v || ack1 !== {3'b000, exp_v}) begin
                    bad++; $display("FAIL edge_pattern[%0d]: got be=%b ack=%b want be=%b",
                                    i, be1, ack1, exp_v);
                end
            end
        end
        req1 = '0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_ignored();
        test_back_to_back();
        test_param_edge();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
